// File: rtl/spi_tx.sv
// spi_tx: SPI master transmitter, MSB first, sclk idle low, cs active low.
//   Shifts out one WIDTH-bit word per cs frame. The receiver samples mosi on
//   the falling sclk edge, and mosi changes only on the rising edge.
//   Optional feature macro: SPI_TX_BURST_EN. When it is defined, a new word can
//   be accepted in the last LOW cycle of a word, so words run back to back
//   under one cs frame.
// Ports:
//   clk, rst          system clock; asynchronous active-high reset
//   tx_data/tx_valid  word to send and its valid flag (sampled only on accept)
//   tx_ready          block can accept a word (accept = tx_valid & tx_ready)
//   busy              frame in progress
//   done              one-cycle pulse after the last bit of a word is shifted out
//   cs, sclk, mosi    SPI outputs, all registered
module spi_tx #(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 4,
   parameter int CS_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             busy,
   output logic             done,
   output logic             cs,
   output logic             sclk,
   output logic             mosi
);
   // the counter also times HOLD, so it must reach CS_HOLD-1 as well
   localparam int CMAX = CLK_DIV > CS_HOLD ? CLK_DIV : CS_HOLD;
   localparam int CW   = $clog2(CMAX) + 1;
   localparam int BW   = $clog2(WIDTH + 1);
   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;
   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [BW-1:0]    bcnt, bcnt_nx;
   logic [WIDTH-1:0] sh, sh_nx, shifted;
   logic             cs_nx, sclk_nx, mosi_nx, done_nx, last, final_bit, accept;
   assign last      = cnt == (state == HOLD ? CW'(CS_HOLD - 1) : CW'(CLK_DIV - 1));
   assign final_bit = bcnt == BW'(WIDTH);
`ifdef SPI_TX_BURST_EN
   assign tx_ready  = state == IDLE || (state == LOW && last && final_bit);
`else
   assign tx_ready  = state == IDLE;
`endif
   assign accept    = tx_valid & tx_ready;
   assign busy      = state != IDLE;
   assign shifted   = sh << 1;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         bcnt  <= '0;
         sh    <= '0;
         cs    <= 1'b1;
         sclk  <= 1'b0;
         mosi  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= state_nx != state ? '0 : cnt + CW'(1);
         bcnt  <= bcnt_nx;
         sh    <= sh_nx;
         cs    <= cs_nx;
         sclk  <= sclk_nx;
         mosi  <= mosi_nx;
         done  <= done_nx;
      end
   end
   always_comb begin
      state_nx = state;
      bcnt_nx  = bcnt;
      sh_nx    = sh;
      cs_nx    = cs;
      sclk_nx  = sclk;
      mosi_nx  = mosi;
      done_nx  = 1'b0;
      case (state)
         IDLE: if (accept) begin
            state_nx = SETUP;
            cs_nx    = 1'b0;
            sh_nx    = tx_data;
            mosi_nx  = tx_data[WIDTH-1];
            bcnt_nx  = '0;
         end
         SETUP: if (last) begin
            state_nx = HIGH;
            sclk_nx  = 1'b1;
         end
         HIGH: if (last) begin
            state_nx = LOW;
            sclk_nx  = 1'b0;
            bcnt_nx  = bcnt + BW'(1);
         end
         LOW: if (last) begin
            if (!final_bit) begin
               // next bit goes out on the rising edge, half a period before the sample
               state_nx = HIGH;
               sclk_nx  = 1'b1;
               sh_nx    = shifted;
               mosi_nx  = shifted[WIDTH-1];
            end else begin
               done_nx  = 1'b1;
               state_nx = HOLD;
`ifdef SPI_TX_BURST_EN
               if (accept) begin
                  state_nx = HIGH;
                  sclk_nx  = 1'b1;
                  sh_nx    = tx_data;
                  mosi_nx  = tx_data[WIDTH-1];
                  bcnt_nx  = '0;
               end
`endif
            end
         end
         HOLD: if (last) begin
            state_nx = GAP;
            cs_nx    = 1'b1;
            mosi_nx  = 1'b0;
         end
         GAP: if (last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_spi_tx.sv
// tb_spi_tx: directed bench for spi_tx with a falling-edge sampling receiver model per instance.
module tb_spi_tx;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] d [2];
   logic [1:0] v = '0;
   logic [1:0] rdy, bsy, dn, cs, sc, mo;
   int         checks = 0, errors = 0;
   always #5 clk = ~clk;
   spi_tx #(.WIDTH(8), .CLK_DIV(4), .CS_HOLD(4)) u0 (
      .clk(clk), .rst(rst), .tx_data(d[0]), .tx_valid(v[0]), .tx_ready(rdy[0]),
      .busy(bsy[0]), .done(dn[0]), .cs(cs[0]), .sclk(sc[0]), .mosi(mo[0]));
   spi_tx #(.WIDTH(8), .CLK_DIV(1), .CS_HOLD(4)) u1 (
      .clk(clk), .rst(rst), .tx_data(d[1]), .tx_valid(v[1]), .tx_ready(rdy[1]),
      .busy(bsy[1]), .done(dn[1]), .cs(cs[1]), .sclk(sc[1]), .mosi(mo[1]));
   genvar g;
   for (g = 0; g < 2; g++) begin : m
      int         bitc = 0, falls = 0, dones = 0, nw = 0, rises = 0;
      logic [7:0] sr = '0;
      logic [7:0] w [16];
      always @(negedge sc[g] or posedge cs[g])
         if (cs[g] !== 1'b0) bitc = 0;
         else begin
            sr = {sr[6:0], mo[g]};
            falls++;
            bitc++;
            if (bitc == 8) begin
               if (nw < 16) w[nw] = sr;
               nw++;
               bitc = 0;
            end
         end
      always @(posedge cs[g]) rises++;
      always @(negedge clk) if (dn[g]) dones++;
   end
   function automatic int falls(input int i);
      return i != 0 ? m[1].falls : m[0].falls;
   endfunction
   function automatic int dones(input int i);
      return i != 0 ? m[1].dones : m[0].dones;
   endfunction
   function automatic int nw(input int i);
      return i != 0 ? m[1].nw : m[0].nw;
   endfunction
   function automatic int rises(input int i);
      return i != 0 ? m[1].rises : m[0].rises;
   endfunction
   function automatic logic [7:0] word(input int i, input int k);
      return i != 0 ? m[1].w[k % 16] : m[0].w[k % 16];
   endfunction
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", n, act, exp);
      end
   endtask
   task automatic chk_idle(input string n, input int i);
      chk({n, "_cs"}, 32'(cs[i]), 1);
      chk({n, "_sclk"}, 32'(sc[i]), 0);
      chk({n, "_mosi"}, 32'(mo[i]), 0);
      chk({n, "_ready"}, 32'(rdy[i]), 1);
      chk({n, "_busy"}, 32'(bsy[i]), 0);
      chk({n, "_done"}, 32'(dn[i]), 0);
   endtask
   // len = accept cycle plus every following cycle with tx_ready low
   task automatic send(input int i, input logic [7:0] data, input logic [7:0] alt, output int len);
      @(negedge clk);
      d[i] = data;
      v[i] = 1'b1;
      @(posedge clk);
      #1;
      v[i] = 1'b0;
      d[i] = alt;
      len  = 1;
      while (!rdy[i] && len < 1000) begin
         len++;
         @(posedge clk);
         #1;
      end
   endtask
   typedef struct {
      int         inst;
      logic [7:0] data;
      logic [7:0] alt;
      int         len;
   } vec_t;
   vec_t tab[6];
   initial begin
      int len, fb, db, nb, rb, t, gap, k;
      logic [7:0] ws [3];
      d[0] = '0;
      d[1] = '0;
      tab[0] = '{0, 8'hA5, 8'hA5, 77};
      tab[1] = '{0, 8'h81, 8'h00, 77};
      tab[2] = '{0, 8'h00, 8'hFF, 77};
      tab[3] = '{0, 8'hFF, 8'h00, 77};
      tab[4] = '{1, 8'h3C, 8'hC3, 23};
      tab[5] = '{1, 8'h81, 8'h7E, 23};
      repeat (3) @(negedge clk);
      chk_idle("rst_on0", 0);
      chk_idle("rst_on1", 1);
      rst = 1'b0;
      @(negedge clk);
      chk_idle("rst_off0", 0);
      chk_idle("rst_off1", 1);
      foreach (tab[j]) begin
         fb = falls(tab[j].inst);
         db = dones(tab[j].inst);
         nb = nw(tab[j].inst);
         send(tab[j].inst, tab[j].data, tab[j].alt, len);
         repeat (2) @(negedge clk);
         chk($sformatf("v%0d_len", j), len, tab[j].len);
         chk($sformatf("v%0d_falls", j), falls(tab[j].inst) - fb, 8);
         chk($sformatf("v%0d_done", j), dones(tab[j].inst) - db, 1);
         chk($sformatf("v%0d_nwords", j), nw(tab[j].inst) - nb, 1);
         chk($sformatf("v%0d_word", j), word(tab[j].inst, nb), tab[j].data);
      end
`ifndef SPI_TX_BURST_EN
      fb = falls(0);
      nb = nw(0);
      @(negedge clk);
      d[0] = 8'h3C;
      v[0] = 1'b1;
      @(posedge clk);
      #1 d[0] = 8'hC3;
      t = 0;
      while (!cs[0] && t < 1000) begin
         @(negedge clk);
         t++;
      end
      gap = 0;
      while (cs[0] && t < 1000) begin
         @(negedge clk);
         gap++;
         t++;
      end
      v[0] = 1'b0;
      while (!rdy[0] && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("t3_timeout", 32'(t < 2000), 1);
      chk("t3_gap", gap, 5);
      chk("t3_falls", falls(0) - fb, 16);
      chk("t3_nwords", nw(0) - nb, 2);
      chk("t3_word0", word(0, nb), 8'h3C);
      chk("t3_word1", word(0, nb + 1), 8'hC3);
`endif
      fb = falls(0);
      nb = nw(0);
      @(negedge clk);
      d[0] = 8'h5A;
      v[0] = 1'b1;
      @(posedge clk);
      #1 v[0] = 1'b0;
      t = 0;
      while (falls(0) - fb < 3 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("t4_timeout", 32'(t < 500), 1);
      #2 rst = 1'b1;
      #1;
      chk_idle("t4_async", 0);
      @(negedge clk);
      rst = 1'b0;
      send(0, 8'hFF, 8'h00, len);
      repeat (2) @(negedge clk);
      chk("t4_nwords", nw(0) - nb, 1);
      chk("t4_word", word(0, nb), 8'hFF);
      chk("t4_len", len, 77);
`ifdef SPI_TX_BURST_EN
      ws[0] = 8'h01;
      ws[1] = 8'h80;
      ws[2] = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         fb = falls(i);
         db = dones(i);
         nb = nw(i);
         rb = rises(i);
         @(negedge clk);
         d[i] = ws[0];
         v[i] = 1'b1;
         k = 0;
         t = 0;
         while (k < 3 && t < 2000) begin
            if (rdy[i]) begin
               @(posedge clk);
               #1;
               k++;
               if (k < 3) d[i] = ws[k];
               else v[i] = 1'b0;
            end else begin
               @(negedge clk);
               t++;
            end
         end
         while (bsy[i] && t < 2000) begin
            @(negedge clk);
            t++;
         end
         @(negedge clk);
         chk($sformatf("b%0d_timeout", i), 32'(t < 2000), 1);
         chk($sformatf("b%0d_falls", i), falls(i) - fb, 24);
         chk($sformatf("b%0d_done", i), dones(i) - db, 3);
         chk($sformatf("b%0d_cs_rises", i), rises(i) - rb, 1);
         chk($sformatf("b%0d_nwords", i), nw(i) - nb, 3);
         for (int j = 0; j < 3; j++)
            chk($sformatf("b%0d_word%0d", i, j), word(i, nb + j), ws[j]);
      end
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
